// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes and special register indices.
// Used by the writeback/register-file slice to decode destination registers.
// Pure declarations; no logic, no latency, no flow control.
package y86_pkg;

    // Instruction codes (icode field of the Y86-64 encoding).
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;  // also every cmovXX
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register indices with architectural meaning.
    localparam logic [3:0] RRSP    = 4'h4;  // stack pointer
    localparam logic [3:0] RNONE   = 4'hF;  // "no register"

endpackage

// File: rtl/regfile_core.sv
// Register storage: NREGS x DATA_W, two write ports, two combinational read ports.
// Latency: writes land on the rising edge with the enable high; reads are zero-cycle.
// No backpressure: callers gate the write enables; rst clears every entry.
//
// Ports:
//   clk, rst          clock and synchronous active-high clear
//   we_e/wa_e/wd_e    write port E
//   we_m/wa_m/wd_m    write port M; wins over E when both target one entry
//   ra_a/rd_a         read port A (out-of-range address reads 0)
//   ra_b/rd_b         read port B (out-of-range address reads 0)
//   regs_flat         all entries, entry i at [i*DATA_W +: DATA_W]
module regfile_core #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we_e,
    input  logic [ADDR_W-1:0]       wa_e,
    input  logic [DATA_W-1:0]       wd_e,
    input  logic                    we_m,
    input  logic [ADDR_W-1:0]       wa_m,
    input  logic [DATA_W-1:0]       wd_m,
    input  logic [ADDR_W-1:0]       ra_a,
    output logic [DATA_W-1:0]       rd_a,
    input  logic [ADDR_W-1:0]       ra_b,
    output logic [DATA_W-1:0]       rd_b,
    output logic [NREGS*DATA_W-1:0] regs_flat
);

    logic [DATA_W-1:0] mem_q [NREGS];

    // Address compare per entry keeps indexing in range for any NREGS,
    // so addresses at or above NREGS simply never select anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (rst) begin
                mem_q[i] <= '0;
            end else if (we_m && (wa_m == ADDR_W'(i))) begin
                mem_q[i] <= wd_m;
            end else if (we_e && (wa_e == ADDR_W'(i))) begin
                mem_q[i] <= wd_e;
            end
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (ra_a == ADDR_W'(i)) rd_a = mem_q[i];
            if (ra_b == ADDR_W'(i)) rd_b = mem_q[i];
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = mem_q[g];
    end

endmodule

// File: rtl/regfile_wb.sv
// Y86-64 writeback stage: destination decode, dual register write, retire counter.
// Latency: commit lands on the next rising edge; reads are combinational.
// Backpressure: wb_stall (or !wb_valid) holds all state; nothing is written or counted.
//
// Optional feature macro: REGFILE_BYPASS_EN -- forwards the committing valM/valE
// onto valA/valB in the same cycle when the read address matches dstM/dstE.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wb_valid, wb_stall    instruction present / hold writeback
//   icode, cnd            instruction code and cmovXX condition
//   rA, rB                register specifiers of the writeback instruction
//   valE, valM            ALU result and memory read data
//   srcA/valA, srcB/valB  two combinational read ports
//   regs_flat             raw register state (never bypassed)
//   retire_cnt            committed-instruction count, wraps at 2**32
module regfile_wb
    import y86_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4,
    parameter int NREGS  = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    input  logic                    wb_stall,
    input  logic [3:0]              icode,
    input  logic                    cnd,
    input  logic [ADDR_W-1:0]       rA,
    input  logic [ADDR_W-1:0]       rB,
    input  logic [DATA_W-1:0]       valE,
    input  logic [DATA_W-1:0]       valM,
    input  logic [ADDR_W-1:0]       srcA,
    input  logic [ADDR_W-1:0]       srcB,
    output logic [DATA_W-1:0]       valA,
    output logic [DATA_W-1:0]       valB,
    output logic [NREGS*DATA_W-1:0] regs_flat,
    output logic [31:0]             retire_cnt
);

    // RNONE is the all-ones index at whatever width ADDR_W selects; the
    // package value is the 4-bit instance of the same thing.
    localparam logic [ADDR_W-1:0] RNONE_W = {ADDR_W{RNONE[0]}};
    localparam logic [ADDR_W-1:0] RRSP_W  = ADDR_W'(RRSP);

    logic                commit;
    logic [ADDR_W-1:0]   dst_e;
    logic [ADDR_W-1:0]   dst_m;
    logic                we_e;
    logic                we_m;
    logic [DATA_W-1:0]   core_rd_a;
    logic [DATA_W-1:0]   core_rd_b;
    logic [31:0]         retire_cnt_q;
    logic [31:0]         retire_cnt_d;

    function automatic logic idx_implemented(input logic [ADDR_W-1:0] idx);
        return (idx != RNONE_W) && (32'(idx) < 32'(NREGS));
    endfunction

    assign commit = wb_valid && !wb_stall && !rst;

    // Destination decode.
    always_comb begin
        dst_e = RNONE_W;
        dst_m = RNONE_W;
        case (icode)
            IRRMOVQ:                     dst_e = cnd ? rB : RNONE_W;
            IIRMOVQ, IOPQ:               dst_e = rB;
            IPUSHQ, IPOPQ, ICALL, IRET:  dst_e = RRSP_W;
            default:                     dst_e = RNONE_W;
        endcase
        case (icode)
            IMRMOVQ, IPOPQ:              dst_m = rA;
            default:                     dst_m = RNONE_W;
        endcase
    end

    // popq %rsp hits the same entry on both ports; the core gives port M
    // priority so the popped value is what survives.
    assign we_e = commit && idx_implemented(dst_e);
    assign we_m = commit && idx_implemented(dst_m);

    regfile_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .we_e      (we_e),
        .wa_e      (dst_e),
        .wd_e      (valE),
        .we_m      (we_m),
        .wa_m      (dst_m),
        .wd_m      (valM),
        .ra_a      (srcA),
        .rd_a      (core_rd_a),
        .ra_b      (srcB),
        .rd_b      (core_rd_b),
        .regs_flat (regs_flat)
    );

`ifdef REGFILE_BYPASS_EN
    // Same-cycle forwarding of the committing results; valM outranks valE
    // to match the write priority.
    function automatic logic [DATA_W-1:0] bypass_rd(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] r;
        r = stored;
        if (commit && (dst_m != RNONE_W) && (src == dst_m)) begin
            r = valM;
        end else if (commit && (dst_e != RNONE_W) && (src == dst_e)) begin
            r = valE;
        end
        return r;
    endfunction

    assign valA = bypass_rd(srcA, core_rd_a);
    assign valB = bypass_rd(srcB, core_rd_b);
`else
    // Stored values only: a write is visible from the cycle after commit.
    assign valA = core_rd_a;
    assign valB = core_rd_b;
`endif

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (commit) begin
            retire_cnt_d = retire_cnt_q + 32'd1;  // wraps naturally
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
// Bypass expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_regfile_wb;
    import y86_pkg::*;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int NREGS  = 15;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wb_valid;
    logic                    wb_stall;
    logic [3:0]              icode;
    logic                    cnd;
    logic [ADDR_W-1:0]       rA;
    logic [ADDR_W-1:0]       rB;
    logic [DATA_W-1:0]       valE;
    logic [DATA_W-1:0]       valM;
    logic [ADDR_W-1:0]       srcA;
    logic [ADDR_W-1:0]       srcB;
    logic [DATA_W-1:0]       valA;
    logic [DATA_W-1:0]       valB;
    logic [NREGS*DATA_W-1:0] regs_flat;
    logic [31:0]             retire_cnt;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    regfile_wb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid   (wb_valid),
        .wb_stall   (wb_stall),
        .icode      (icode),
        .cnd        (cnd),
        .rA         (rA),
        .rB         (rB),
        .valE       (valE),
        .valM       (valM),
        .srcA       (srcA),
        .srcB       (srcB),
        .valA       (valA),
        .valB       (valB),
        .regs_flat  (regs_flat),
        .retire_cnt (retire_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] reg_at(input int i);
        return regs_flat[i*DATA_W +: DATA_W];
    endfunction

    // Present one writeback instruction; caller then samples and/or ticks.
    task automatic set_wb(input logic v, input logic st, input logic [3:0] ic, input logic c,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [63:0] e, input logic [63:0] m);
        wb_valid = v;
        wb_stall = st;
        icode    = ic;
        cnd      = c;
        rA       = a;
        rB       = b;
        valE     = e;
        valM     = m;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        srcA = 4'hF;
        srcB = 4'hF;
        set_wb(1'b0, 1'b0, INOP, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        srcA = 4'd3;
        srcB = 4'd6;
        #1;
        check_eq("rst_valA", valA, 64'h0);
        check_eq("rst_valB", valB, 64'h0);
        check_eq("rst_flat_zero", {63'h0, regs_flat == '0}, 64'h1);
        check_eq("rst_cnt", {32'h0, retire_cnt}, 64'h0);

        // irmovq -> r3, visible the cycle after commit
        set_wb(1'b1, 1'b0, IIRMOVQ, 1'b0, 4'hF, 4'd3, 64'h1234, 64'h0);
`ifdef REGFILE_BYPASS_EN
        check_eq("irmovq_same_cycle", valA, 64'h1234);
`else
        check_eq("irmovq_same_cycle", valA, 64'h0);
`endif
        tick();
        set_wb(1'b0, 1'b0, INOP, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        check_eq("irmovq_valA", valA, 64'h1234);
        check_eq("irmovq_cnt", {32'h0, retire_cnt}, 64'h1);

        // popq %rsp: dstE == dstM == 4, valM wins
        set_wb(1'b1, 1'b0, IPOPQ, 1'b0, 4'd4, 4'hF, 64'h100, 64'hBEEF);
        tick();
        check_eq("popq_rsp_r4", reg_at(4), 64'hBEEF);
        check_eq("popq_rsp_cnt", {32'h0, retire_cnt}, 64'h2);

        // popq %rdx: both ports land in different registers
        set_wb(1'b1, 1'b0, IPOPQ, 1'b0, 4'd2, 4'hF, 64'h300, 64'h77);
        tick();
        check_eq("popq_r2", reg_at(2), 64'h77);
        check_eq("popq_r4", reg_at(4), 64'h300);

        // cmovXX not taken, then taken
        set_wb(1'b1, 1'b0, IRRMOVQ, 1'b0, 4'd0, 4'd2, 64'h5, 64'h0);
        tick();
        check_eq("cmov_nt_r2", reg_at(2), 64'h77);
        check_eq("cmov_nt_cnt", {32'h0, retire_cnt}, 64'h4);
        set_wb(1'b1, 1'b0, IRRMOVQ, 1'b1, 4'd0, 4'd2, 64'h5, 64'h0);
        tick();
        check_eq("cmov_t_r2", reg_at(2), 64'h5);
        check_eq("cmov_t_cnt", {32'h0, retire_cnt}, 64'h5);

        // OPq held by stall, then released
        set_wb(1'b1, 1'b1, IOPQ, 1'b0, 4'd0, 4'd1, 64'h7, 64'h0);
        tick();
        check_eq("stall_r1", reg_at(1), 64'h0);
        check_eq("stall_cnt", {32'h0, retire_cnt}, 64'h5);
        set_wb(1'b1, 1'b0, IOPQ, 1'b0, 4'd0, 4'd1, 64'h7, 64'h0);
        tick();
        check_eq("unstall_r1", reg_at(1), 64'h7);
        check_eq("unstall_cnt", {32'h0, retire_cnt}, 64'h6);

        // wb_valid low: no write, no count
        set_wb(1'b0, 1'b0, IIRMOVQ, 1'b0, 4'hF, 4'd3, 64'h999, 64'h0);
        tick();
        check_eq("novalid_r3", reg_at(3), 64'h1234);
        check_eq("novalid_cnt", {32'h0, retire_cnt}, 64'h6);

        // pushq updates %rsp from valE
        set_wb(1'b1, 1'b0, IPUSHQ, 1'b0, 4'd1, 4'hF, 64'h200, 64'h0);
        tick();
        check_eq("pushq_r4", reg_at(4), 64'h200);

        // mrmovq -> r6 twice; second read of r6 in the commit cycle
        set_wb(1'b1, 1'b0, IMRMOVQ, 1'b0, 4'd6, 4'd0, 64'h0, 64'h11);
        tick();
        srcA = 4'd3;
        srcB = 4'd6;
        set_wb(1'b1, 1'b0, IMRMOVQ, 1'b0, 4'd6, 4'd0, 64'hAAAA, 64'h55);
`ifdef REGFILE_BYPASS_EN
        check_eq("mrmovq_bypass_valB", valB, 64'h55);
`else
        check_eq("mrmovq_bypass_valB", valB, 64'h11);
`endif
        check_eq("mrmovq_other_valA", valA, 64'h1234);
        check_eq("mrmovq_flat_old", reg_at(6), 64'h11);
        tick();
        check_eq("mrmovq_r6", reg_at(6), 64'h55);
        check_eq("mrmovq_cnt", {32'h0, retire_cnt}, 64'h9);

        // popq %rsp read in the commit cycle: valM outranks valE
        srcA = 4'd4;
        set_wb(1'b1, 1'b0, IPOPQ, 1'b0, 4'd4, 4'hF, 64'h400, 64'h500);
`ifdef REGFILE_BYPASS_EN
        check_eq("popq_bypass_valA", valA, 64'h500);
`else
        check_eq("popq_bypass_valA", valA, 64'h200);
`endif
        tick();
        check_eq("popq2_r4", reg_at(4), 64'h500);

        // RNONE read returns 0
        srcA = 4'hF;
        set_wb(1'b0, 1'b0, INOP, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        check_eq("rnone_valA", valA, 64'h0);

        // Reset overrides a simultaneous commit to r5
        rst = 1'b1;
        srcA = 4'd3;
        set_wb(1'b1, 1'b0, IIRMOVQ, 1'b0, 4'hF, 4'd5, 64'hAA, 64'h0);
        tick();
        check_eq("rstcommit_r5", reg_at(5), 64'h0);
        check_eq("rstcommit_r3", reg_at(3), 64'h0);
        check_eq("rstcommit_cnt", {32'h0, retire_cnt}, 64'h0);
        check_eq("rstcommit_valA", valA, 64'h0);
        rst = 1'b0;
        set_wb(1'b0, 1'b0, INOP, 1'b0, 4'hF, 4'hF, 64'h0, 64'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
